// File: rtl/wptr_full_ctrl.sv
// Write-side pointer and full-flag controller for an asynchronous FIFO.
// Optional registered almost-full output is enabled by defining WPTR_ALMOST_FULL_EN.
module wptr_full_ctrl #(
  parameter int          ADDR_WIDTH   = 4,
  parameter int unsigned AFULL_THRESH = 12
) (
  input  logic                  w_clk,
  input  logic                  w_rst_n,
  input  logic                  w_inc,
  input  logic [ADDR_WIDTH:0]   r_ptr_gray,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH:0]   w_ptr_gray,
  output logic                  w_full,
  output logic [ADDR_WIDTH:0]   w_level,
  output logic                  w_overflow
`ifdef WPTR_ALMOST_FULL_EN
  ,output logic                 w_almost_full
`endif
);

  localparam int AW = ADDR_WIDTH;

  function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
    logic [AW:0] b;
    b[AW] = g[AW];
    for (int i = AW - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [AW:0] w_bin_q, w_bin_d;
  logic [AW:0] w_gray_q, w_gray_d;
  logic [AW:0] wq1_q, wq2_q;
  logic        w_full_q, w_full_d;
  logic        w_overflow_q, w_overflow_d;
  logic        accept;
  logic [AW:0] r_bin_sync;

  assign accept     = w_inc & ~w_full_q;
  assign r_bin_sync = gray2bin(wq2_q);

  always_comb begin
    w_bin_d      = w_bin_q + {{AW{1'b0}}, accept};
    w_gray_d     = w_bin_d ^ (w_bin_d >> 1);
    // Full when the write pointer has lapped the synchronized read pointer once.
    w_full_d     = (w_gray_d == {~wq2_q[AW:AW-1], wq2_q[AW-2:0]});
    w_overflow_d = w_overflow_q | (w_inc & w_full_q);
  end

  always_ff @(posedge w_clk) begin
    if (!w_rst_n) begin
      w_bin_q      <= '0;
      w_gray_q     <= '0;
      wq1_q        <= '0;
      wq2_q        <= '0;
      w_full_q     <= 1'b0;
      w_overflow_q <= 1'b0;
    end else begin
      w_bin_q      <= w_bin_d;
      w_gray_q     <= w_gray_d;
      wq1_q        <= r_ptr_gray;
      wq2_q        <= wq1_q;
      w_full_q     <= w_full_d;
      w_overflow_q <= w_overflow_d;
    end
  end

  assign w_addr     = w_bin_q[AW-1:0];
  assign w_ptr_gray = w_gray_q;
  assign w_full     = w_full_q;
  assign w_level    = w_bin_q - r_bin_sync;
  assign w_overflow = w_overflow_q;

`ifdef WPTR_ALMOST_FULL_EN
  logic        w_almost_full_q, w_almost_full_d;
  logic [AW:0] af_diff;

  always_comb begin
    af_diff         = w_bin_d - r_bin_sync;
    w_almost_full_d = ({{(31 - AW){1'b0}}, af_diff} >= AFULL_THRESH);
  end

  always_ff @(posedge w_clk) begin
    if (!w_rst_n) begin
      w_almost_full_q <= 1'b0;
    end else begin
      w_almost_full_q <= w_almost_full_d;
    end
  end

  assign w_almost_full = w_almost_full_q;
`endif

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Directed bench for wptr_full_ctrl (ADDR_WIDTH=4): reset, fill, overflow,
// full release, pointer wrap, and almost-full when WPTR_ALMOST_FULL_EN is set.
module tb_wptr_full_ctrl;

  localparam int AW = 4;

  logic          w_clk;
  logic          w_rst_n;
  logic          w_inc;
  logic [AW:0]   r_ptr_gray;
  logic [AW-1:0] w_addr;
  logic [AW:0]   w_ptr_gray;
  logic          w_full;
  logic [AW:0]   w_level;
  logic          w_overflow;
`ifdef WPTR_ALMOST_FULL_EN
  logic          w_almost_full;
`endif

  int checks;
  int fails;

  wptr_full_ctrl #(.ADDR_WIDTH(AW), .AFULL_THRESH(12)) dut (
    .w_clk         (w_clk),
    .w_rst_n       (w_rst_n),
    .w_inc         (w_inc),
    .r_ptr_gray    (r_ptr_gray),
    .w_addr        (w_addr),
    .w_ptr_gray    (w_ptr_gray),
    .w_full        (w_full),
    .w_level       (w_level),
    .w_overflow    (w_overflow)
`ifdef WPTR_ALMOST_FULL_EN
    ,.w_almost_full(w_almost_full)
`endif
  );

  // Clock and reset
  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  function automatic logic [AW:0] gray(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  // Advance one active edge and settle past it before checking or driving.
  task automatic step();
    @(posedge w_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [AW:0] exp_bin;
    checks = 0;
    fails  = 0;

    // Reset held 3 cycles with write requests asserted
    w_rst_n    = 1'b0;
    w_inc      = 1'b1;
    r_ptr_gray = '0;
    repeat (3) step();
    check("rst_addr",     32'(w_addr),     32'd0);
    check("rst_gray",     32'(w_ptr_gray), 32'd0);
    check("rst_full",     32'(w_full),     32'd0);
    check("rst_level",    32'(w_level),    32'd0);
    check("rst_overflow", 32'(w_overflow), 32'd0);
    w_inc   = 1'b0;
    w_rst_n = 1'b1;
    step();
    check("post_rst_addr",  32'(w_addr),  32'd0);
    check("post_rst_level", 32'(w_level), 32'd0);

    // Fill with 16 writes, reader parked at 0
    w_inc = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("fill_addr", 32'(w_addr), 32'(i));
      check("fill_full_low", 32'(w_full), 32'd0);
      step();
      if (i == 0) check("fill_gray_first", 32'(w_ptr_gray), 32'h01);
    end
    w_inc = 1'b0;
    check("fill_full",  32'(w_full),     32'd1);
    check("fill_level", 32'(w_level),    32'd16);
    check("fill_gray",  32'(w_ptr_gray), 32'h18);
    check("fill_addr_wrap", 32'(w_addr), 32'd0);

    // Write while full is dropped and sets sticky overflow
    w_inc = 1'b1;
    step();
    w_inc = 1'b0;
    check("ovf_addr", 32'(w_addr),     32'd0);
    check("ovf_gray", 32'(w_ptr_gray), 32'h18);
    check("ovf_flag", 32'(w_overflow), 32'd1);
    for (int i = 0; i < 20; i++) begin
      step();
      check("ovf_sticky", 32'(w_overflow), 32'd1);
    end

    // Release one entry: full drops on the third edge
    r_ptr_gray = 5'b00001;
    step();
    check("rel_full_e1", 32'(w_full), 32'd1);
    step();
    check("rel_full_e2", 32'(w_full), 32'd1);
    step();
    check("rel_full_e3",  32'(w_full),  32'd0);
    check("rel_level",    32'(w_level), 32'd15);
    check("rel_addr",     32'(w_addr),  32'd0);
    w_inc = 1'b1;
    step();
    w_inc = 1'b0;
    check("rel_wr_addr",  32'(w_addr),     32'd1);
    check("rel_wr_gray",  32'(w_ptr_gray), 32'h19);
    check("rel_wr_full",  32'(w_full),     32'd1);
    check("rel_wr_level", 32'(w_level),    32'd16);

    // Mid-operation reset discards pointer state and overflow
    w_rst_n    = 1'b0;
    r_ptr_gray = '0;
    repeat (2) step();
    w_rst_n = 1'b1;
    check("rst2_addr",     32'(w_addr),     32'd0);
    check("rst2_overflow", 32'(w_overflow), 32'd0);
    check("rst2_full",     32'(w_full),     32'd0);

    // 40 writes with reader two entries behind: pointer wraps, never full
    exp_bin = '0;
    w_inc   = 1'b1;
    for (int i = 0; i < 40; i++) begin
      r_ptr_gray = (i >= 2) ? gray(5'(i - 2)) : 5'd0;
      check("wrap_addr", 32'(w_addr), 32'(exp_bin[AW-1:0]));
      step();
      exp_bin = exp_bin + 5'd1;
      check("wrap_gray", 32'(w_ptr_gray), 32'(gray(exp_bin)));
      check("wrap_full", 32'(w_full), 32'd0);
      if (exp_bin == 5'd31) check("wrap_gray_31", 32'(w_ptr_gray), 32'h10);
      if (i == 31)          check("wrap_gray_0",  32'(w_ptr_gray), 32'h00);
    end
    w_inc      = 1'b0;
    r_ptr_gray = gray(5'd6);
    repeat (3) step();
    check("wrap_level", 32'(w_level), 32'd2);
    check("wrap_addr_end", 32'(w_addr), 32'd8);

`ifdef WPTR_ALMOST_FULL_EN
    w_rst_n    = 1'b0;
    r_ptr_gray = '0;
    repeat (2) step();
    w_rst_n = 1'b1;
    check("af_rst", 32'(w_almost_full), 32'd0);
    w_inc = 1'b1;
    for (int i = 0; i < 12; i++) begin
      check("af_low", 32'(w_almost_full), 32'd0);
      step();
    end
    w_inc = 1'b0;
    check("af_high", 32'(w_almost_full), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  // Watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule
